seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU, successor to the single-cycle datapath ALU.
//  - Adds unsigned multiply and divide, run iteratively one bit per cycle.
//  - Uses a start/busy/done handshake and registered result, result_hi and zero outputs.
//  - Sits in the EX stage. The controller stalls while busy=1.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      launch an operation; sampled only in IDLE
//  func       in   3      0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 SLT,6 MULU,7 DIVU
//  inp1       in   WIDTH  operand A (dividend / multiplicand)
//  inp2       in   WIDTH  operand B (divisor / multiplier)
//  out        out  WIDTH  result low word / quotient
//  result_hi  out  WIDTH  MULU high word / DIVU remainder; 0 for other ops
//  zero       out  1      1 when out==0 (registered with out)
//  busy       out  1      1 while an operation is in flight
//  done       out  1      1-cycle pulse when out/result_hi/zero are updated
// BEHAVIOUR
//  - Reset (async, any state, mid-operation included):
//    - State goes to IDLE; out=0, result_hi=0, zero=1, busy=0, done=0.
//    - Any in-flight operation is discarded.
//  - FSM states:
//    - IDLE: start=1 captures func/inp1/inp2. Next state is EXEC for func 0-5 and MUL/DIV for func 6/7.
//    - EXEC: single cycle. Writes the result, pulses done, then returns to IDLE.
//    - MUL/DIV: WIDTH iterations, counter counts WIDTH-1 down to 0. At count 0 the FSM writes results, pulses done and returns to IDLE.
//  - busy=1 in EXEC, MUL and DIV.
//  - start is ignored while busy=1; no queueing.
//  - A start in the done cycle is accepted, because the FSM is already in IDLE that cycle.
//  - Latency from the start edge to the done edge: func 0-5 = 2 cycles; MULU/DIVU = WIDTH+1 cycles.
//  - out/result_hi/zero hold their value until the next done. They do not change while busy=1.
//  - Operands are registered at start; input changes while busy=1 have no effect.
//  - Arithmetic, all mod 2^WIDTH:
//    - ADD/SUB wrap; no carry or overflow output.
//    - AND/OR are bitwise.
//    - SLT: unsigned inp1<inp2 gives out = all ones, else 0.
//    - NOP: out=0.
//    - result_hi=0 for func 0-5.
//  - MULU: shift-add, 2*WIDTH-bit product. out = low word, result_hi = high word.
//  - DIVU: restoring division. out = quotient, result_hi = remainder.
//  - DIVU with inp2==0: out = all ones, result_hi = inp1. Still takes full latency and is not flagged.
//  - zero is computed from the final out only, never from result_hi.
// CONFIGURATION
//  ALU_DIVIDER_EN defined:
//    - DIVU behaves as above.
//  ALU_DIVIDER_EN undefined:
//    - No divider logic is instantiated.
//    - func 7 is treated as NOP: out=0, result_hi=0, zero=1, single-cycle EXEC path (latency 2).
// TESTING
//  1. rst pulse mid-MULU (cycle 5) -> next edge busy=0, done=0, out=0, result_hi=0, zero=1; done never fires for the dropped op.
//  2. ADD 32'hFFFF_FFFF+1 -> done after 2 cycles; out=0, zero=1. SUB 3-5 -> out=32'hFFFF_FFFE, zero=0.
//  3. SLT 5,7 -> out=32'hFFFF_FFFF. SLT 32'h8000_0000,1 -> out=0 (unsigned compare).
//  4. MULU 32'hFFFF_FFFF x 2 -> done exactly 33 cycles after start; result_hi=1, out=32'hFFFF_FFFE. A second start while busy is ignored.
//  5. DIVU 100/7 -> out=14, result_hi=2. DIVU 9/0 -> out=32'hFFFF_FFFF, result_hi=9.
//     Without ALU_DIVIDER_EN: DIVU 100/7 -> out=0, zero=1, done at 2 cycles.
//  6. Back-to-back: start ADD 1+2 then start ORI in the done cycle -> both accepted; done pulses 2 cycles apart; out=3 then OR value.

Source files
------------

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu - multi-cycle ALU for the EX stage
//
// Single-cycle ops (NOP/ADD/SUB/AND/OR/SLT) take one EXEC cycle. MULU
// (shift-add) and DIVU (restoring) iterate one bit per cycle for WIDTH
// cycles. The controller stalls while busy=1. Results are registered and
// hold their value until the next done pulse.
//
// Configuration macro: ALU_DIVIDER_EN
//   defined   : func 7 is DIVU (quotient on out, remainder on result_hi)
//   undefined : no divider logic; func 7 behaves as NOP on the EXEC path
//
// Parameters
//   WIDTH      operand/result width in bits (>= 4)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      launch an operation; only looked at in IDLE
//   func       0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 SLT,6 MULU,7 DIVU
//   inp1       operand A (dividend / multiplicand)
//   inp2       operand B (divisor / multiplier)
//   out        result low word / quotient
//   result_hi  MULU high word / DIVU remainder, 0 for other ops
//   zero       out == 0, updated together with out
//   busy       operation in flight
//   done       one-cycle pulse when out/result_hi/zero are updated
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] F_ADD  = 3'd1;
  localparam logic [2:0] F_SUB  = 3'd2;
  localparam logic [2:0] F_AND  = 3'd3;
  localparam logic [2:0] F_OR   = 3'd4;
  localparam logic [2:0] F_SLT  = 3'd5;
  localparam logic [2:0] F_MULU = 3'd6;
`ifdef ALU_DIVIDER_EN
  localparam logic [2:0] F_DIVU = 3'd7;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL
`ifdef ALU_DIVIDER_EN
    , S_DIV
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       func_reg, func_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  // Shared iteration registers: hi = partial product / partial remainder,
  // lo = multiplier shifting out / dividend shifting out, quotient shifting in.
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] rhi_reg, rhi_next;
  logic             zero_reg, zero_next;
  logic             done_reg, done_next;

  // ---------------------------------------------------------------------------
  // Single-cycle result
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] exec_res;

  always_comb begin
    exec_res = '0;
    case (func_reg)
      F_ADD:   exec_res = a_reg + b_reg;
      F_SUB:   exec_res = a_reg - b_reg;
      F_AND:   exec_res = a_reg & b_reg;
      F_OR:    exec_res = a_reg | b_reg;
      F_SLT:   exec_res = {WIDTH{a_reg < b_reg}};
      default: exec_res = '0;  // NOP, and func 7 when the divider is absent
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply step: add multiplicand if the current multiplier bit is set,
  // then shift the {carry, hi, lo} chain right by one.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  always_comb begin
    mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_reg[WIDTH-1:1]};
  end

`ifdef ALU_DIVIDER_EN
  // ---------------------------------------------------------------------------
  // Restoring divide step: shift next dividend bit into the remainder, keep
  // the subtraction only when it does not go negative. With a zero divisor
  // every step subtracts nothing, which yields quotient all-ones and
  // remainder = dividend without any special casing.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  always_comb begin
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_reg});
    div_diff  = div_shift - {1'b0, b_reg};
    div_hi    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo    = {lo_reg[WIDTH-2:0], div_ge};
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    func_next  = func_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    rhi_next   = rhi_reg;
    zero_next  = zero_reg;
    done_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          func_next = func;
          a_next    = inp1;
          b_next    = inp2;
          hi_next   = '0;
          lo_next   = (func == F_MULU) ? inp2 : inp1;
          cnt_next  = CW'(WIDTH - 1);
          case (func)
            F_MULU:  state_next = S_MUL;
`ifdef ALU_DIVIDER_EN
            F_DIVU:  state_next = S_DIV;
`endif
            default: state_next = S_EXEC;
          endcase
        end
      end

      S_EXEC: begin
        out_next   = exec_res;
        rhi_next   = '0;
        zero_next  = (exec_res == '0);
        done_next  = 1'b1;
        state_next = S_IDLE;
      end

      S_MUL: begin
        hi_next  = mul_hi;
        lo_next  = mul_lo;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == '0) begin
          out_next   = mul_lo;
          rhi_next   = mul_hi;
          zero_next  = (mul_lo == '0);
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end

`ifdef ALU_DIVIDER_EN
      S_DIV: begin
        hi_next  = div_hi;
        lo_next  = div_lo;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == '0) begin
          out_next   = div_lo;
          rhi_next   = div_hi;
          zero_next  = (div_lo == '0);
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
`endif

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      func_reg  <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      rhi_reg   <= '0;
      zero_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      func_reg  <= func_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      rhi_reg   <= rhi_next;
      zero_reg  <= zero_next;
      done_reg  <= done_next;
    end
  end

  assign out       = out_reg;
  assign result_hi = rhi_reg;
  assign zero      = zero_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule
